// File: rtl/and16_serial_pkg.sv
// Shared types and constants for the bit-serial AND datapath.
package and16_serial_pkg;

    localparam int HACK_WORD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/and_gate.sv
// 1-bit AND primitive; the serial datapath routes every result bit through one instance.
module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i & b_i;

endmodule

// File: rtl/and16_serial.sv
// Bit-serial AND: operands captured over valid/ready, LSB-first through one and_gate,
// result shifted in from the top and returned over a second valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand pair, last result still visible on out
// BUSY  | one result bit per edge, WIDTH edges total
// DONE  | result valid, held until the consumer takes it
module and16_serial
    import and16_serial_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_w;

    and_gate u_and_gate (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .y_o (bit_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)             state_d = BUSY;
            BUSY:    if (cnt_q == CNT_LAST)    state_d = DONE;
            DONE:    if (out_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath next-state: load on accept, shift one bit per BUSY edge.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    res_d  = '0;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_w, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_ONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign out = res_q;

endmodule

// File: tb/tb_and16_serial.sv
// Self-checking bench for and16_serial: directed cases plus a random stream
// checked against a queue of expected a&b results.
module tb_and16_serial;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a, op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dut_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];

    and16_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dut_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs only change just after posedge, so the negedge view predicts the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(op_a & op_b);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_underflow", exp_q.size(), 1);
                else
                    chk("sb_out", dut_out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_in_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, in_ready, 1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({tag, "_done_timeout"}, out_valid, 1);
    endtask

    // Called just after a posedge with out_ready=1; checks latency cycle by cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
        op_a = ta;
        op_b = tb_v;
        in_valid = 1'b1;
        wait_in_ready(tag);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = ~ta;
        op_b = ~tb_v;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (i < W) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
                    chk({tag, "_busy_flags"}, {out_valid, in_ready, busy}, 3'b001);
                else
                    checks++;
            end else begin
                chk({tag, "_valid_at_W"}, out_valid, 1);
                chk({tag, "_out"}, dut_out, ta & tb_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] prev;
        int last_acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            @(negedge clk);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out", dut_out, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'hFFFF, 16'h0F0F, "basic");
        chk("basic_idle", in_ready, 1);
        run_op(16'hAAAA, 16'h5555, "alt");
        run_op(16'h8001, 16'hFFFF, "ends");
        run_op(16'h1234, 16'hFF00, "mixed");

        // Backpressure in DONE with pending operands
        out_ready = 1'b0;
        op_a = 16'hC3C3;
        op_b = 16'hFF0F;
        in_valid = 1'b1;
        wait_in_ready("bp");
        @(posedge clk);
        #1;
        op_a = 16'h5A5A;
        op_b = 16'h0FF0;
        wait_out_valid("bp");
        prev = dut_out;
        chk("bp_first_out", prev, 16'hC303);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_out_stable", dut_out, 16'hC303);
            chk("bp_no_accept", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1);
        @(negedge clk);
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_pending_accepted", busy, 1);
        wait_out_valid("bp2");
        chk("bp2_out", dut_out, 16'h0A50);
        @(posedge clk);
        #1;

        // Abort after cnt reaches 7
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        in_valid = 1'b1;
        wait_in_ready("rst_mid");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", dut_out, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) chk("mid_rst_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_op(16'h1234, 16'hFFFF, "after_rst");

        // Random stream, both handshakes held open
        last_acc  = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            wait_in_ready("stream");
            if (i > 0) chk("stream_spacing", cyc - last_acc, W + 2);
            last_acc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_out_valid("stream_tail");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
